// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 key schedule controller.
package aes_pkg;

    typedef logic [0:255] key256_t;
    typedef logic [0:127] rkey_t;

    localparam int AES256_NUM_RK   = 15;
    localparam int AES256_NUM_ITER = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ks_state_e;

endpackage

// File: rtl/rk_buffer.sv
// Round-key register file: one write port (a 256-bit write fills an even entry
// and optionally the odd entry above it), one registered read port with
// zero-fill for addresses beyond the last entry.
module rk_buffer
    import aes_pkg::*;
#(
    parameter int NUM_RK = AES256_NUM_RK
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           we_i,
    input  logic           pair_i,
    input  logic [3:0]     widx_i,
    input  logic [0:255]   wdata_i,
    input  logic           rd_v_i,
    input  logic [3:0]     rd_addr_i,
    output logic           rd_v_o,
    output logic [0:127]   rd_data_o
);

    rkey_t mem_q [NUM_RK];
    rkey_t rd_word;
    rkey_t rd_data_q;
    logic  rd_v_q;

    // Storage is deliberately not reset; widx_i is always even so |1 selects the odd partner.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i[0:127];
            if (pair_i) begin
                mem_q[widx_i | 4'd1] <= wdata_i[128:255];
            end
        end
    end

    // Read mux with zero-fill for out-of-range indices.
    always_comb begin
        rd_word = '0;
        if (rd_addr_i < 4'(NUM_RK)) begin
            rd_word = mem_q[rd_addr_i];
        end
    end

    // Registered read; data holds when no read is requested.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_v_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_v_q <= rd_v_i;
            if (rd_v_i) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign rd_v_o    = rd_v_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-256 key schedule sequencer. Takes one cipher key, drives the external
// round_key pipeline for NUM_ITER iterations (inputs held for RK_LATENCY+1
// cycles each), and stores the round keys in rk_buffer for indexed reads.
// Handshake: a key transfers on a rising edge where key_v_i and key_ready_o are
// both high; key_ready_o is high only in IDLE/DONE and never depends on key_v_i.
// NUM_RK is expected to equal 2*NUM_ITER+1.
module key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int RK_LATENCY = 10,
    parameter int NUM_RK     = AES256_NUM_RK,
    parameter int NUM_ITER   = AES256_NUM_ITER
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           key_v_i,
    input  logic [0:255]   key_i,
    output logic           key_ready_o,
    output logic [0:255]   rk_k_o,
    output logic [0:3]     rk_r_o,
    input  logic [0:255]   rk_result_i,
    input  logic           rd_v_i,
    input  logic [3:0]     rd_addr_i,
    output logic           rd_v_o,
    output logic [0:127]   rd_data_o,
    output logic           keys_ready_o,
    output logic           busy_o,
    output logic [1:0]     dbg_state_o
);

    localparam int ITER_W = $clog2(NUM_ITER + 1);
    localparam int CNT_W  = $clog2(RK_LATENCY + 1);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_ITER);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RK_LATENCY);

    ks_state_e         state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    key256_t           rk_k_q, rk_k_d;
    logic [0:3]        rk_r_q, rk_r_d;
    logic              keys_ready_q, keys_ready_d;
    logic              busy_q, busy_d;

    logic              buf_we;
    logic              buf_pair;
    logic [3:0]        buf_widx;
    key256_t           buf_wdata;

    // Control and round_key input registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            iter_q       <= '0;
            cnt_q        <= '0;
            rk_k_q       <= '0;
            rk_r_q       <= '0;
            keys_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            cnt_q        <= cnt_d;
            rk_k_q       <= rk_k_d;
            rk_r_q       <= rk_r_d;
            keys_ready_q <= keys_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: accept, issue, wait out the pipeline latency, capture.
    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        cnt_d        = cnt_q;
        rk_k_d       = rk_k_q;
        rk_r_d       = rk_r_q;
        keys_ready_d = keys_ready_q;
        busy_d       = busy_q;
        buf_we       = 1'b0;
        buf_pair     = 1'b0;
        buf_widx     = '0;
        buf_wdata    = rk_result_i;

        case (state_q)
            IDLE, DONE: begin
                if (key_v_i) begin
                    buf_we       = 1'b1;
                    buf_pair     = 1'b1;
                    buf_widx     = 4'd0;
                    buf_wdata    = key_i;
                    rk_k_d       = key_i;
                    rk_r_d       = 4'd1;
                    iter_d       = ITER_ONE;
                    keys_ready_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_ONE;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    buf_we   = 1'b1;
                    buf_widx = 4'({iter_q, 1'b0});
                    if (iter_q != ITER_LAST) begin
                        buf_pair = 1'b1;
                        rk_k_d   = rk_result_i;
                        rk_r_d   = 4'(iter_q) + 4'd1;
                        iter_d   = iter_q + ITER_ONE;
                        state_d  = ISSUE;
                    end else begin
                        // Last iteration: only the lower half is a round key.
                        keys_ready_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    rk_buffer #(.NUM_RK(NUM_RK)) u_rk_buffer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .we_i      (buf_we),
        .pair_i    (buf_pair),
        .widx_i    (buf_widx),
        .wdata_i   (buf_wdata),
        .rd_v_i    (rd_v_i),
        .rd_addr_i (rd_addr_i),
        .rd_v_o    (rd_v_o),
        .rd_data_o (rd_data_o)
    );

    // Ready is forced low while reset is held so every output reads zero in reset.
    assign key_ready_o  = reset_n_i & ((state_q == IDLE) | (state_q == DONE));
    assign rk_k_o       = rk_k_q;
    assign rk_r_o       = rk_r_q;
    assign keys_ready_o = keys_ready_q;
    assign busy_o       = busy_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with a latency-accurate AES-256 round_key model.
module tb_key_schedule_ctrl;

  localparam int L = 10;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic         key_v_i;
  logic [255:0] key_i;
  logic         key_ready_o;
  logic [255:0] rk_k_o;
  logic [3:0]   rk_r_o;
  logic [255:0] rk_result_i;
  logic         rd_v_i;
  logic [3:0]   rd_addr_i;
  logic         rd_v_o;
  logic [127:0] rd_data_o;
  logic         keys_ready_o;
  logic         busy_o;
  logic [1:0]   dbg_state_o;

  key_schedule_ctrl #(.RK_LATENCY(L)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .key_v_i      (key_v_i),
    .key_i        (key_i),
    .key_ready_o  (key_ready_o),
    .rk_k_o       (rk_k_o),
    .rk_r_o       (rk_r_o),
    .rk_result_i  (rk_result_i),
    .rd_v_i       (rd_v_i),
    .rd_addr_i    (rd_addr_i),
    .rd_v_o       (rd_v_o),
    .rd_data_o    (rd_data_o),
    .keys_ready_o (keys_ready_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- AES-256 reference ----------------
  logic [7:0]   sbox [256];
  logic [255:0] exp_st [0:7];
  logic [127:0] exp_rk [0:14];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, a8, b8;
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      inv = 8'h00;
      if (a != 0) begin
        for (int b = 1; b < 256; b++) begin
          b8 = 8'(b);
          if (gmul(a8, b8) == 8'h01) inv = b8;
        end
      end
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [255:0] ks_step(input logic [255:0] s, input logic [3:0] r);
    logic [31:0] w [16];
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = s[255 - 32*i -: 32];
    rc = (r >= 4'd1 && r <= 4'd7) ? (8'h01 << (r - 4'd1)) : 8'h00;
    w[8] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rc, 24'h0};
    for (int i = 9; i < 12; i++) w[i] = w[i-8] ^ w[i-1];
    w[12] = w[4] ^ sub_word(w[11]);
    for (int i = 13; i < 16; i++) w[i] = w[i-8] ^ w[i-1];
    return {w[8], w[9], w[10], w[11], w[12], w[13], w[14], w[15]};
  endfunction

  task automatic make_keys(input logic [255:0] k);
    exp_st[0] = k;
    for (int r = 1; r < 8; r++) exp_st[r] = ks_step(exp_st[r-1], 4'(r));
    exp_rk[0] = k[255:128];
    exp_rk[1] = k[127:0];
    for (int r = 1; r < 8; r++) begin
      exp_rk[2*r] = exp_st[r][255:128];
      if (r < 7) exp_rk[2*r+1] = exp_st[r][127:0];
    end
  endtask

  // External round_key stand-in: L register stages after the combinational step.
  logic [255:0] pipe_q [L];
  always @(posedge clk_i) begin
    pipe_q[0] <= ks_step(rk_k_o, rk_r_o);
    for (int i = 1; i < L; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign rk_result_i = pipe_q[L-1];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  int           addr_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Read monitor: pops one expectation for every valid read response.
  always @(negedge clk_i) begin
    logic [127:0] e;
    int a;
    if (reset_n_i && rd_v_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=no_response", rd_data_o);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL rd_data[%0d] actual=%0h required=%0h", a, rd_data_o, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic read_push(input int a, input logic [127:0] e);
    rd_v_i = 1'b1;
    rd_addr_i = 4'(a);
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    check("rd_v_lag", rd_v_o, 1);
  endtask

  task automatic read_idle();
    rd_v_i = 1'b0;
    tick();
    check("rd_v_low", rd_v_o, 0);
    tick();
    check("rd_queue_drained", exp_q.size(), 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) read_push(a, (a < 15) ? exp_rk[a] : 128'h0);
    read_push(14, exp_rk[14]);
    read_idle();
    tick();
    check("rd_data_hold", rd_data_o, exp_rk[14]);
  endtask

  // Load one key and follow the expansion; pa/pb inject a competing key, rst_at
  // asserts reset at that cycle and abandons the run.
  task automatic run_key(input logic [255:0] k, input logic [255:0] k2,
                         input int pa, input int pb, input int rst_at);
    int n, bad, ri, t;
    int hold [8];
    logic [3:0] prev_r;
    bit aborted;
    make_keys(k);
    key_i = k;
    key_v_i = 1'b1;
    t = 0;
    while (!key_ready_o && t < 50) begin tick(); t++; end
    check("key_ready_before_accept", key_ready_o, 1);
    @(posedge clk_i); #1;
    key_v_i = 1'b0;
    n = 1;
    check("keys_ready_drop", keys_ready_o, 0);
    bad = 0; prev_r = 4'd0; aborted = 1'b0;
    for (int i = 0; i < 8; i++) hold[i] = 0;
    while (!keys_ready_o && n < 200 && !aborted) begin
      if (!busy_o || key_ready_o) bad++;
      ri = int'(rk_r_o);
      if (rk_r_o != prev_r) begin
        check("rk_r_step", rk_r_o, prev_r + 4'd1);
        if (ri >= 1 && ri <= 7) check("rk_k_prev_result", rk_k_o, exp_st[ri-1]);
        prev_r = rk_r_o;
      end
      if (ri >= 1 && ri <= 7) hold[ri]++;
      if (n == rst_at) begin
        reset_n_i = 1'b0;
        #1;
        check("rst_key_ready", key_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_keys_ready", keys_ready_o, 0);
        check("rst_rd_v", rd_v_o, 0);
        check("rst_rk_k", rk_k_o, 0);
        check("rst_rk_r", rk_r_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_state", dbg_state_o, 0);
        tick();
        reset_n_i = 1'b1;
        aborted = 1'b1;
      end else begin
        key_v_i = (n == pa || n == pb);
        key_i   = (n == pa || n == pb) ? k2 : k;
        tick();
        n++;
      end
    end
    key_v_i = 1'b0;
    key_i = k;
    if (!aborted) begin
      check("keys_ready_latency", n, 78);
      check("busy_not_ready_during_run", bad, 0);
      for (int r = 1; r < 8; r++) check($sformatf("rk_r_hold[%0d]", r), hold[r], 11);
      check("done_busy", busy_o, 0);
      check("done_key_ready", key_ready_o, 1);
      check("done_state", dbg_state_o, 3);
    end
  endtask

  // ---------------- main sequence ----------------
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_64 = {32{8'h64}};
  localparam logic [255:0] KEY_11 = {32{8'h11}};

  initial begin
    build_sbox();
    reset_n_i = 1'b0;
    key_v_i = 1'b0;
    key_i = '0;
    rd_v_i = 1'b0;
    rd_addr_i = '0;
    repeat (3) tick();
    check("reset_key_ready", key_ready_o, 0);
    check("reset_keys_ready", keys_ready_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_rd_v", rd_v_o, 0);
    check("reset_rk_k", rk_k_o, 0);
    check("reset_rk_r", rk_r_o, 0);
    check("reset_rd_data", rd_data_o, 0);
    reset_n_i = 1'b1;
    tick();
    check("idle_key_ready", key_ready_o, 1);
    check("idle_state", dbg_state_o, 0);

    // FIPS-197 A.3 key with published round keys.
    run_key(KEY_A3, '0, -1, -1, -1);
    read_push(1,  128'h1f352c073b6108d72d9810a30914dff4);
    read_push(2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    read_push(3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    read_push(14, 128'hfe4890d1e6188d0b046df344706c631e);
    read_idle();
    read_all();

    // Re-key in DONE with the all-0x64 key.
    run_key(KEY_64, '0, -1, -1, -1);
    read_push(0, 128'h64646464646464646464646464646464);
    read_push(1, 128'h64646464646464646464646464646464);
    read_idle();
    read_all();

    // Competing key pulses while busy must be ignored.
    run_key(KEY_A3, KEY_11, 5, 30, -1);
    repeat (3) tick();
    check("pulse_not_taken_keys_ready", keys_ready_o, 1);
    check("pulse_not_taken_busy", busy_o, 0);
    read_all();

    // Reset in the middle of an expansion, then a clean A.3 expansion.
    run_key(KEY_64, '0, -1, -1, 40);
    tick();
    check("post_rst_key_ready", key_ready_o, 1);
    check("post_rst_keys_ready", keys_ready_o, 0);
    run_key(KEY_A3, '0, -1, -1, -1);
    read_push(2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    read_push(14, 128'hfe4890d1e6188d0b046df344706c631e);
    read_idle();
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequencer for the AES-256 round_key expansion datapath. It accepts one 256-bit cipher key over a valid/ready handshake and issues round indices 1..7 to an external round_key pipeline, holding each input stable for that pipeline's fixed latency. It captures each 256-bit result into a 15-entry round-key buffer (round keys 0..14, 128 bits each). The cipher core reads this buffer by index with a 1-cycle registered read.

Parameters:
RK_LATENCY, 10, cycles from a stable rk_k_o/rk_r_o to a valid rk_result_i (must be >= 1)
NUM_RK, 15, number of 128-bit round keys stored (AES-256)
NUM_ITER, 7, expansion iterations issued to round_key

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
key_v_i  in  1  cipher key valid
key_i  in  [0:255]  cipher key, MSB-first byte order
key_ready_o  out  1  controller can accept a key
rk_k_o  out  [0:255]  previous 256-bit key state to round_key
rk_r_o  out  [0:3]  iteration index to round_key
rk_result_i  in  [0:255]  expanded 256-bit state from round_key
rd_v_i  in  1  round-key read request
rd_addr_i  in  [3:0]  round-key index 0..14
rd_v_o  out  1  read data valid, 1 cycle after rd_v_i
rd_data_o  out  [0:127]  round key at rd_addr_i
keys_ready_o  out  1  all NUM_RK round keys valid
busy_o  out  1  expansion in progress

Behaviour:
- Reset (async assert, sync release): state=IDLE; key_ready_o=1 after release. keys_ready_o, busy_o, rd_v_o=0. rk_k_o, rk_r_o, rd_data_o=0. Buffer contents are not reset.
- States: IDLE, ISSUE, WAIT, DONE. key_ready_o=1 only in IDLE and DONE.
- Accept at edge with key_v_i & key_ready_o:
  - buf[0]<=key_i[0:127], buf[1]<=key_i[128:255], rk_k_o<=key_i, rk_r_o<=1, iter<=1.
  - keys_ready_o<=0, busy_o<=1, state->ISSUE.
- ISSUE: one cycle, inputs presented; cnt<=1; ->WAIT.
- WAIT: cnt increments each cycle. On the cycle where cnt==RK_LATENCY, capture rk_result_i at the closing edge:
  - buf[2*iter]<=rk_result_i[0:127].
  - If iter<7: buf[2*iter+1]<=rk_result_i[128:255]; rk_k_o<=rk_result_i; rk_r_o<=iter+1; iter++; ->ISSUE.
  - If iter==7: the upper half is discarded; ->DONE; keys_ready_o<=1; busy_o<=0.
- rk_k_o/rk_r_o change only at accept or capture edges; they are held constant through each ISSUE+WAIT window.
- Timing: each iteration takes RK_LATENCY+1 cycles. With accept at cycle T0, keys_ready_o is first high at cycle T0+1+7*(RK_LATENCY+1), i.e. T0+78 for the default.
- DONE: holds keys indefinitely. A new key accepted in DONE re-keys and drops keys_ready_o on the next cycle.
- key_v_i while busy: ignored, not queued. The source must hold key_v_i until ready.
- Reads:
  - Accepted in any state, one per cycle, fully pipelined: rd_v_o<=rd_v_i; rd_data_o<=buf[rd_addr_i].
  - rd_addr_i>14 returns zero.
  - Reads during expansion return whatever the entry currently holds; consumers gate on keys_ready_o.
  - Read and capture of the same entry on the same edge returns the old value.
  - rd_data_o holds its value when rd_v_i=0.
- Reset mid-expansion: immediate return to IDLE; keys_ready_o=0; partial buffer contents are invalid.
- iter and cnt are sized for NUM_ITER and RK_LATENCY. cnt never wraps; it is reloaded on each ISSUE.

Decomposition:
- aes_pkg holds:
  - typedefs key256_t [0:255] and rkey_t [0:127];
  - constants AES256_NUM_RK=15, AES256_NUM_ITER=7;
  - state enum ks_state_e {IDLE, ISSUE, WAIT, DONE}.
- One sub-module, rk_buffer: 15x128 register file with one write port and a registered read port with zero-fill for out-of-range addresses.
- round_key stays external to this block. The top level connects it, so the bench can substitute a latency-accurate model.

Test Plan:
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, latency 10 -> keys_ready_o rises exactly 78 cycles after accept. Required reads:
  - rd 1 = 1f352c073b6108d72d9810a30914dff4
  - rd 2 = 9ba354118e6925afa51a8b5f2067fcde
  - rd 3 = a8b09c1a93d194cdbe49846eb75d5b9a
  - rd 14 = fe4890d1e6188d0b046df344706c631e
- Key of all 0x64 bytes -> rk_r_o steps 1,2,..,7, each held for exactly 11 cycles. rk_k_o equals the previous rk_result_i at each step. buf[0]=buf[1]=64..64.
- key_v_i pulsed at cycles 5 and 30 after the first accept -> key_ready_o=0 and busy_o=1 throughout; the second key is not taken; the result matches the first key only.
- reset_n_i asserted at cycle 40 of an expansion -> all outputs 0 asynchronously. Then re-key with the A.3 key -> correct keys, and keys_ready_o at +78 cycles.
- Back-to-back reads of addresses 0..15 in DONE -> rd_v_o follows with 1-cycle lag; address 15 returns 0.
- Re-key in DONE with the all-0x64 key -> keys_ready_o drops the next cycle, then reasserts 78 cycles after accept with the new buf[2]..buf[14].
